// File: rtl/barrett_modmul_ctrl_if.sv
// rtl/barrett_modmul_ctrl_if.sv - config, operand, result and multiplier signals of the Barrett modmul controller
interface barrett_modmul_ctrl_if #(
  parameter int W  = 64,
  parameter int KW = 7
);
  // modulus configuration
  logic            cfg_we;
  logic [W-1:0]    cfg_q;
  logic [W-1:0]    cfg_mu;
  logic [KW-1:0]   cfg_k;
  logic            cfg_ready;

  // operand pair in
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_a;
  logic [W-1:0]    in_b;

  // shared external multiplier
  logic            mul_start;
  logic [W-1:0]    mul_a;
  logic [W-1:0]    mul_b;
  logic            mul_done;
  logic [2*W-1:0]  mul_p;

  // reduced result out
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_t;
  logic            out_err;

  // controller side
  modport slave (
    input  cfg_we, cfg_q, cfg_mu, cfg_k,
    output cfg_ready,
    input  in_valid, in_a, in_b,
    output in_ready,
    output mul_start, mul_a, mul_b,
    input  mul_done, mul_p,
    output out_valid, out_t, out_err,
    input  out_ready
  );

  // operand source / multiplier / result sink side
  modport master (
    output cfg_we, cfg_q, cfg_mu, cfg_k,
    input  cfg_ready,
    output in_valid, in_a, in_b,
    input  in_ready,
    input  mul_start, mul_a, mul_b,
    output mul_done, mul_p,
    input  out_valid, out_t, out_err,
    output out_ready
  );
endinterface

// File: rtl/barrett_modmul_ctrl.sv
// rtl/barrett_modmul_ctrl.sv - Barrett (a*b) mod q sequencer over one shared multiplier; optional BARRETT_RANGE_CHECK_EN
module barrett_modmul_ctrl #(
  parameter int W  = 64,
  parameter int KW = 7
) (
  input logic                   clk,
  input logic                   rst,
  barrett_modmul_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MZ   = 3'd1,
    M2   = 3'd2,
    M3   = 3'd3,
    SUB  = 3'd4,
    COR  = 3'd5,
    DONE = 3'd6
  } state_t;

  state_t         state;
  state_t         state_next;

  // modulus configuration
  logic [W-1:0]   q_r;
  logic [W-1:0]   mu_r;
  logic [KW-1:0]  k_r;

  // low half of z = a*b; the high half only feeds the next multiply directly
  logic [W-1:0]   z_lo;
  logic [W-1:0]   t_r;
  logic [1:0]     corr_cnt;

  logic           mul_start_r;
  logic [W-1:0]   mul_a_r;
  logic [W-1:0]   mul_b_r;

  logic           accept;
  logic           cfg_load;
  logic           t_ge_q;
  logic           range_bad;

  assign t_ge_q = (t_r >= q_r);

  // state register; reset aborts any op in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next state, handshake decisions and state-decoded outputs
  always_comb begin
    state_next    = state;
    accept        = 1'b0;
    cfg_load      = 1'b0;
    bus.cfg_ready = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.cfg_ready = 1'b1;
        bus.in_ready  = 1'b1;
        // an operand handshake takes priority over a same-cycle config write
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = MZ;
        end else if (bus.cfg_we) begin
          cfg_load   = 1'b1;
        end
      end
      MZ: begin
        if (bus.mul_done) state_next = M2;
      end
      M2: begin
        if (bus.mul_done) state_next = M3;
      end
      M3: begin
        if (bus.mul_done) state_next = SUB;
      end
      SUB: begin
        state_next = COR;
      end
      COR: begin
        if (!t_ge_q) state_next = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // config registers, multiplier operand sequencing and the t reduction datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r         <= '0;
      mu_r        <= '0;
      k_r         <= '0;
      z_lo        <= '0;
      t_r         <= '0;
      corr_cnt    <= '0;
      mul_start_r <= 1'b0;
      mul_a_r     <= '0;
      mul_b_r     <= '0;
    end else begin
      mul_start_r <= 1'b0;
      if (cfg_load) begin
        q_r  <= bus.cfg_q;
        mu_r <= bus.cfg_mu;
        k_r  <= bus.cfg_k;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            mul_a_r     <= bus.in_a;
            mul_b_r     <= bus.in_b;
            mul_start_r <= 1'b1;
          end
        end
        MZ: begin
          // z>>(k-1) < 2^(k+1) <= 2^(W-1), so the truncation to W bits is lossless
          if (bus.mul_done) begin
            z_lo        <= bus.mul_p[W-1:0];
            mul_a_r     <= W'(bus.mul_p >> (k_r - KW'(1)));
            mul_b_r     <= mu_r;
            mul_start_r <= 1'b1;
          end
        end
        M2: begin
          // m3 = ((z>>(k-1))*mu)>>(k+1) is an estimate of floor(z/q), below 2^(k+1)
          if (bus.mul_done) begin
            mul_a_r     <= W'(bus.mul_p >> (k_r + KW'(1)));
            mul_b_r     <= q_r;
            mul_start_r <= 1'b1;
          end
        end
        M3: begin
          // z - m3*q < 3q < 2^W, so the low halves alone give the exact difference
          if (bus.mul_done) begin
            t_r     <= z_lo - bus.mul_p[W-1:0];
            mul_a_r <= '0;
            mul_b_r <= '0;
          end
        end
        SUB: begin
          corr_cnt <= '0;
        end
        COR: begin
          if (t_ge_q) begin
            t_r <= t_r - q_r;
            if (corr_cnt != 2'd3) corr_cnt <= corr_cnt + 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef BARRETT_RANGE_CHECK_EN
  logic err_r;

  // operand range flag, re-evaluated on every operand handshake against the live q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (accept) begin
      err_r <= (bus.in_a >= q_r) || (bus.in_b >= q_r);
    end
  end

  assign range_bad   = err_r;
  assign bus.out_err = err_r & (state == DONE);
`else
  assign range_bad   = 1'b0;
  assign bus.out_err = 1'b0;
`endif

  assign bus.mul_start = mul_start_r;
  assign bus.mul_a     = mul_a_r;
  assign bus.mul_b     = mul_b_r;
  assign bus.out_t     = (state == DONE) ? t_r : '0;

  // a third correction means mu/k do not match q
  a_corr_bound : assert property (@(posedge clk) disable iff (rst)
    (state == COR && t_ge_q && !range_bad) |-> (corr_cnt < 2'd2));

endmodule

// File: tb/tb_barrett_modmul_ctrl.sv
// tb/tb_barrett_modmul_ctrl.sv - scoreboard bench for barrett_modmul_ctrl with a behavioural multiplier model
module tb_barrett_modmul_ctrl;
  localparam int W  = 64;
  localparam int KW = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  barrett_modmul_ctrl_if #(.W(W), .KW(KW)) bus ();
  barrett_modmul_ctrl #(.W(W), .KW(KW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [W-1:0] t;
    logic         err;
    int           lat;
    int           hs;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           lat_mode = 0;
  int           rdy_mode = 0;
  logic [W-1:0] cur_q = '0;
  logic [W-1:0] cur_mu = '0;
  int           cur_k = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  // Barrett reference from plain 128-bit arithmetic: value is (a*b)%q, corrections derived from the estimate
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input bit fixed_lat);
    exp_t e;
    logic [127:0] z, m3, t, tpre, corr;
    z    = {64'd0, a} * {64'd0, b};
    t    = z % {64'd0, cur_q};
    m3   = ((z >> (cur_k - 1)) * {64'd0, cur_mu}) >> (cur_k + 1);
    tpre = z - m3 * {64'd0, cur_q};
    corr = (tpre - t) / {64'd0, cur_q};
    e.t  = t[W-1:0];
`ifdef BARRETT_RANGE_CHECK_EN
    e.err = (a >= cur_q) || (b >= cur_q);
`else
    e.err = 1'b0;
`endif
    e.lat = fixed_lat ? (3 * (3 + 1) + 2 + int'(corr)) : -1;
    e.hs  = 0;
    return e;
  endfunction

  // behavioural multiplier: product appears L cycles after the start pulse
  initial begin
    int cnt;
    logic [W-1:0] ma, mb;
    cnt = 0; ma = '0; mb = '0;
    bus.mul_done = 1'b0;
    bus.mul_p    = '0;
    forever begin
      @(posedge clk); #1;
      bus.mul_done = 1'b0;
      if (rst) begin
        cnt = 0;
      end else if (bus.mul_start) begin
        ma  = bus.mul_a;
        mb  = bus.mul_b;
        cnt = (lat_mode == 0) ? 3 : int'($urandom_range(1, 8));
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.mul_done = 1'b1;
          bus.mul_p    = {64'd0, ma} * {64'd0, mb};
        end
      end
    end
  end

  // result sink
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // monitor: stability while stalled, then pop-and-compare on acceptance
  initial begin
    bit           seen;
    int           first_cyc;
    logic [W-1:0] held_t;
    exp_t         e;
    seen = 0; first_cyc = 0; held_t = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 0;
      end else if (bus.out_valid) begin
        if (!seen) begin
          seen      = 1;
          first_cyc = cyc;
          held_t    = bus.out_t;
        end else begin
          chk("hold_out_t", bus.out_t, held_t);
          chk("done_in_ready", bus.in_ready, 0);
          chk("done_cfg_ready", bus.cfg_ready, 0);
        end
        if (bus.out_ready) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result: got %0d expected none", bus.out_t);
          end else begin
            e = sb.pop_front();
            chk("out_t", bus.out_t, e.t);
            chk("out_err", bus.out_err, e.err);
            if (e.lat >= 0) chk("latency", first_cyc - e.hs, e.lat);
          end
          seen = 0;
        end
      end
    end
  end

  task automatic wait_in_ready();
    int n;
    n = 0;
    while (!bus.in_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
  endtask

  task automatic set_cfg(input logic [W-1:0] q, input logic [W-1:0] mu, input int k);
    wait_in_ready();
    bus.cfg_we = 1'b1; bus.cfg_q = q; bus.cfg_mu = mu; bus.cfg_k = KW'(k);
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    cur_q = q; cur_mu = mu; cur_k = k;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    wait_in_ready();
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    e    = model(a, b, lat_mode == 0);
    e.hs = cyc;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !bus.in_ready) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic rand_cfg();
    int k;
    logic [W-1:0] q, r;
    logic [127:0] mu;
    k  = int'($urandom_range(2, W - 2));
    r  = {$urandom(), $urandom()};
    q  = (64'd1 << (k - 1)) | (r & ((64'd1 << (k - 1)) - 64'd1));
    mu = (128'd1 << (2 * k)) / {64'd0, q};
    set_cfg(q, mu[W-1:0], k);
  endtask

  task automatic rand_ops(input int n);
    logic [W-1:0] a, b;
    for (int i = 0; i < n; i++) begin
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      send(a % cur_q, b % cur_q);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_mul_start"}, bus.mul_start, 0);
    chk({tag, "_mul_a"}, bus.mul_a, 0);
    chk({tag, "_mul_b"}, bus.mul_b, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_t"}, bus.out_t, 0);
    chk({tag, "_out_err"}, bus.out_err, 0);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_cfg_ready"}, bus.cfg_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.cfg_we = 1'b0; bus.cfg_q = '0; bus.cfg_mu = '0; bus.cfg_k = '0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // known vectors, fixed L=3
    lat_mode = 0; rdy_mode = 0;
    set_cfg(64'd97, 64'd168, 7);
    send(64'd50, 64'd60);
    send(64'd96, 64'd96);
    send(64'd0, 64'd96);
    drain();
    set_cfg((64'd1 << 61) - 64'd1, (64'd1 << 61) + 64'd1, 61);
    send((64'd1 << 61) - 64'd2, (64'd1 << 61) - 64'd2);
    drain();

    // stalled sink with config writes attempted mid-op and alongside a handshake
    set_cfg(64'd97, 64'd168, 7);
    rdy_mode = 2;
    send(64'd96, 64'd95);
    bus.cfg_we = 1'b1; bus.cfg_q = 64'd5; bus.cfg_mu = 64'd3; bus.cfg_k = 7'd3;
    n = 0;
    while (!bus.out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("stall_out_valid", bus.out_valid, 1);
    repeat (10) @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
    rdy_mode = 0;
    drain();
    bus.cfg_we = 1'b1; bus.cfg_q = 64'd5; bus.cfg_mu = 64'd3; bus.cfg_k = 7'd3;
    send(64'd77, 64'd88);
    bus.cfg_we = 1'b0;
    send(64'd13, 64'd94);
    drain();

    // reset while the second multiply is in flight
    send(64'd50, 64'd60);
    repeat (5) @(posedge clk);
    #1;
    chk("m2_mul_a", bus.mul_a, 64'd46);
    chk("m2_mul_b", bus.mul_b, 64'd168);
    #3 rst = 1'b1;
    #1;
    check_idle_outputs("midop_reset");
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    set_cfg(64'd97, 64'd168, 7);
    send(64'd96, 64'd96);
    drain();

`ifdef BARRETT_RANGE_CHECK_EN
    send(64'd97, 64'd1);
    send(64'd1, 64'd1);
    drain();
`endif

    // random configs and operands, fixed latency with a random sink
    rdy_mode = 1;
    for (int c = 0; c < 6; c++) begin
      rand_cfg();
      rand_ops(8);
      drain();
    end

    // random multiplier latency 1..8
    lat_mode = 1;
    for (int c = 0; c < 6; c++) begin
      rand_cfg();
      rand_ops(8);
      drain();
    end
    rdy_mode = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
